// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file for the
// RISC-V datapath, with optional write-to-read bypass, optional registered
// reads and a sequential clear engine that zeroes one register per cycle.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous reset, active-low
//   we        write enable
//   waddr     write address (AW bits)
//   wdata     write data (XLEN bits)
//   raddr     packed read addresses, port i = raddr[i*AW +: AW]
//   rdata     packed read data, port i = rdata[i*XLEN +: XLEN]
//   clr_req   request a clear sweep of all registers
//   clr_busy  high while the sweep runs
//   clr_done  one-cycle pulse on the final sweep cycle
//   wr_drop   one-cycle pulse after a write was ignored during a sweep
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                wr_drop
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_ok;
    logic            ptr_last;

    // Writes land only while idle; x0 is never stored.
    assign wr_ok    = we && (waddr != '0) && (state == IDLE);
    assign ptr_last = (ptr == AW'(NREGS - 1));
    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= AW'(1);
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                // Gated by rst so a reset landing on the last sweep cycle
                // suppresses the completion pulse.
                clr_done = ptr_last && rst;
                ptr_nxt  = ptr + AW'(1);
                if (ptr_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage: reset wipes everything at once, the sweep wipes one entry
    // per cycle and blocks normal writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            wr_drop <= 1'b0;
        else
            wr_drop <= (state == CLEAR) && we && (waddr != '0);
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] sel_p0;

        assign ra = raddr[g*AW +: AW];

        // Port selection: zero for x0 and during a sweep, forwarded write
        // data on an address match when bypass is enabled.
        always_comb begin
            sel_p0 = '0;
            if ((state == IDLE) && (ra != '0)) begin
                if ((BYPASS != 0) && wr_ok && (waddr == ra))
                    sel_p0 = wdata;
                else
                    sel_p0 = mem[ra];
            end
        end

        if (READ_LAT != 0) begin : g_reg
            logic [XLEN-1:0] rd_p1;

            // Registered read stage
            always_ff @(posedge clk) begin
                if (!rst)
                    rd_p1 <= '0;
                else
                    rd_p1 <= sel_p0;
            end

            assign rdata[g*XLEN +: XLEN] = (state == CLEAR) ? '0 : rd_p1;
        end else begin : g_comb
            assign rdata[g*XLEN +: XLEN] = rst ? sel_p0 : '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        clr_req;

    // u0: bypass, comb read; u1: no bypass, comb read; u2: bypass, registered read
    logic [63:0] rdv    [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic        drop_v [3];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m  [NR];
    bit          mbusy;
    int          mptr;
    bit          mdrop;
    logic [31:0] mq [2];

    // Last observed values
    logic [31:0] lrd [3][2];
    logic        lbusy, ldone, ldrop;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(NR), .AW(5), .NRD(2), .BYPASS(1), .READ_LAT(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdv[0]), .clr_req(clr_req), .clr_busy(busy_v[0]), .clr_done(done_v[0]),
        .wr_drop(drop_v[0]));

    regfile_mp #(.XLEN(32), .NREGS(NR), .AW(5), .NRD(2), .BYPASS(0), .READ_LAT(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdv[1]), .clr_req(clr_req), .clr_busy(busy_v[1]), .clr_done(done_v[1]),
        .wr_drop(drop_v[1]));

    regfile_mp #(.XLEN(32), .NREGS(NR), .AW(5), .NRD(2), .BYPASS(1), .READ_LAT(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdv[2]), .clr_req(clr_req), .clr_busy(busy_v[2]), .clr_done(done_v[2]),
        .wr_drop(drop_v[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value a port should select this cycle (before any reset gating).
    function automatic logic [31:0] exp_sel(input int ra, input bit byp);
        if (mbusy || ra == 0) return 32'h0;
        if (byp && we && (int'(waddr) == ra) && waddr != 5'd0) return wdata;
        return m[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m[i] = 32'h0;
        mbusy = 1'b0;
        mptr  = 1;
        mdrop = 1'b0;
        mq[0] = 32'h0;
        mq[1] = 32'h0;
    endtask

    task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input int ra0, input int ra1, input bit cr);
        int          ra [2];
        logic [31:0] e  [3];
        ra[0]   = ra0;
        ra[1]   = ra1;
        rst     = r;
        we      = w;
        waddr   = wa[4:0];
        wdata   = wd;
        raddr   = {ra1[4:0], ra0[4:0]};
        clr_req = cr;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("busy_u%0d", d), {63'h0, busy_v[d]}, {63'h0, mbusy});
            chk($sformatf("done_u%0d", d), {63'h0, done_v[d]},
                {63'h0, (r && mbusy && mptr == NR - 1)});
            chk($sformatf("drop_u%0d", d), {63'h0, drop_v[d]}, {63'h0, mdrop});
        end
        for (int p = 0; p < 2; p++) begin
            e[0] = r ? exp_sel(ra[p], 1'b1) : 32'h0;
            e[1] = r ? exp_sel(ra[p], 1'b0) : 32'h0;
            e[2] = mbusy ? 32'h0 : mq[p];
            for (int d = 0; d < 3; d++) begin
                lrd[d][p] = rdv[d][p*32 +: 32];
                chk($sformatf("rd%0d_u%0d_a%0d", p, d, ra[p]), {32'h0, lrd[d][p]}, {32'h0, e[d]});
            end
        end
        lbusy = busy_v[0];
        ldone = done_v[0];
        ldrop = drop_v[0];
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) mq[p] = exp_sel(ra[p], 1'b1);
            mdrop = mbusy && w && wa != 0;
            if (mbusy) begin
                m[mptr] = 32'h0;
                if (mptr == NR - 1) begin
                    mbusy = 1'b0;
                    mptr  = 1;
                end else begin
                    mptr++;
                end
            end else begin
                if (w && wa != 0) m[wa] = wd;
                if (cr) mbusy = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, done_at;
        bit w;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset clears preloaded registers
        step(1, 1, 5, 32'd7, 0, 0, 0);
        step(1, 1, 9, 32'd3, 5, 9, 0);
        step(0, 0, 0, 32'h0, 5, 9, 0);
        step(1, 0, 0, 32'h0, 5, 9, 0);
        chk("rst_x5", {32'h0, lrd[0][0]}, 64'h0);
        chk("rst_x9", {32'h0, lrd[0][1]}, 64'h0);
        chk("rst_busy", {63'h0, lbusy}, 64'h0);

        // Write / read, x0 hardwired
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(1, 0, 0, 32'h0, 5, 0, 0);
        chk("wr_x5", {32'h0, lrd[0][0]}, 64'hDEADBEEF);
        chk("rd_x0", {32'h0, lrd[0][1]}, 64'h0);
        step(1, 1, 0, 32'h77, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 0);
        chk("x0_u0", {32'h0, lrd[0][0]}, 64'h0);
        chk("x0_u1", {32'h0, lrd[1][0]}, 64'h0);

        // Bypass versus no bypass
        step(1, 1, 7, 32'h1111, 0, 0, 0);
        step(1, 1, 7, 32'h1234, 7, 7, 0);
        chk("byp_on", {32'h0, lrd[0][0]}, 64'h1234);
        chk("byp_off", {32'h0, lrd[1][0]}, 64'h1111);

        // Registered read latency
        step(1, 1, 3, 32'h55, 0, 0, 0);
        step(1, 0, 0, 32'h0, 3, 0, 0);
        step(1, 1, 3, 32'hAA, 3, 0, 0);
        chk("rl1_x3", {32'h0, lrd[2][0]}, 64'h55);
        step(1, 0, 0, 32'h0, 3, 0, 0);
        chk("rl1_bypass", {32'h0, lrd[2][0]}, 64'hAA);

        // Clear sweep with a dropped write
        step(1, 0, 0, 32'h0, 5, 4, 1);
        bc = 0; dc = 0; done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            w = (k == 5);
            step(1, w, 4, 32'h999, 4, 5, 0);
            if (k == 6) chk("wr_drop", {63'h0, ldrop}, 64'h1);
            if (lbusy) bc++;
            if (ldone) begin
                dc++;
                done_at = bc;
            end
            if (!lbusy) break;
        end
        chk("sweep_len", 64'(bc), 64'd31);
        chk("done_cnt", 64'(dc), 64'd1);
        chk("done_last", 64'(done_at), 64'd31);
        step(1, 0, 0, 32'h0, 4, 5, 0);
        chk("post_x4", {32'h0, lrd[0][0]}, 64'h0);
        chk("post_x5", {32'h0, lrd[0][1]}, 64'h0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 32'h0, i, i + 16, 0);

        // Reset during a sweep
        step(1, 1, 12, 32'h12, 0, 0, 0);
        step(1, 1, 20, 32'h20, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 1);
        for (int k = 1; k <= 9; k++) step(1, 0, 0, 32'h0, 12, 20, 0);
        step(0, 0, 0, 32'h0, 12, 20, 0);
        step(1, 1, 12, 32'hABC, 12, 20, 0);
        chk("mid_busy", {63'h0, lbusy}, 64'h0);
        chk("mid_done", {63'h0, ldone}, 64'h0);
        step(1, 0, 0, 32'h0, 12, 20, 0);
        chk("mid_x12", {32'h0, lrd[0][0]}, 64'hABC);
        chk("mid_x20", {32'h0, lrd[0][1]}, 64'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 500; n++) begin
            int wa, ra0, ra1;
            bit r, wv, cr;
            r   = ($urandom_range(0, 59) != 0);
            wv  = $urandom_range(0, 1);
            wa  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7);
            ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
            ra1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, NR - 1);
            cr  = ($urandom_range(0, 49) == 0);
            step(r, wv, wa, $urandom, ra0, ra1, cr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
